divide: RTL and testbench
=========================

DIVIDE -- requirements
Module: divide

Interface
REQ-001 SHALL have parameter BITS, default 32, giving operand width; BITS even, >= 4.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port clr  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port start  input  1  request; sampled only while idle.
REQ-005 SHALL have port dividend  input  BITS  signed two's-complement numerator.
REQ-006 SHALL have port divisor  input  BITS  signed two's-complement denominator.
REQ-007 SHALL have port busy  output  1  high while a division is in progress.
REQ-008 SHALL have port done  output  1  one-cycle pulse when results are updated.
REQ-009 SHALL have port quotient  output  BITS  signed quotient (LO destination).
REQ-010 SHALL have port remainder  output  BITS  signed remainder (HI destination).
REQ-011 SHALL have port div_by_zero  output  1  set with done when divisor was zero.

Function
REQ-012 SHALL implement states IDLE, RUN, FIX; IDLE->RUN on start, RUN->FIX after BITS iterations, FIX->IDLE unconditionally.
REQ-013 SHALL, on the edge sampling start in IDLE (edge E0), capture dividend/divisor signs and magnitudes, clear the partial remainder, and zero the iteration counter.
REQ-014 SHALL perform one restoring (or non-restoring) quotient-bit iteration per edge E1..E_BITS on an unsigned BITS+1-bit partial remainder.
REQ-015 SHALL, at edge E_BITS+1 (FIX), apply sign correction, load quotient, remainder, div_by_zero, and assert done; latency = BITS+1 edges after E0 (33 for BITS=32).
REQ-016 SHALL truncate toward zero: quotient negative iff operand signs differ and result nonzero; remainder takes dividend's sign; |remainder| < |divisor|.
REQ-017 SHALL handle dividend = most-negative, divisor = -1 by wrap: quotient = 0x80000000 (BITS=32), remainder = 0, no flag.
REQ-018 SHALL, for divisor = 0, complete with identical latency giving quotient = all ones, remainder = dividend, div_by_zero = 1.
REQ-019 SHALL drive busy high from after E0 through the FIX edge; busy low in the done cycle.
REQ-020 SHALL ignore start while busy; operand changes after E0 SHALL not affect the result.
REQ-021 SHALL accept start during the done cycle (state IDLE), beginning a new division back-to-back.
REQ-022 SHALL hold quotient, remainder, div_by_zero stable from done until the next FIX edge.

Reset
REQ-023 SHALL, on clr low, asynchronously force state IDLE, busy 0, done 0, quotient 0, remainder 0, div_by_zero 0, counter 0.
REQ-024 SHALL abort any in-progress division on reset with no done pulse; first start after clr high SHALL behave as from power-up.

Structure
REQ-025 SHALL place default BITS, state encoding, and counter width (clog2(BITS)+1) in a shared package with the arithmetic blocks.
REQ-026 SHALL reuse the codebase negate module as its single sub-module for two's-complement magnitude and sign correction.
REQ-027 SHALL contain no combinational loop from start to busy/done; all outputs registered.

Verification
REQ-028 SHALL cover 100 / 7 -> quotient 14, remainder 2, done exactly 33 edges after start edge.
REQ-029 SHALL cover -100 / 7 -> quotient 0xFFFFFFF2, remainder 0xFFFFFFFE; 100 / -7 -> 0xFFFFFFF2, 2.
REQ-030 SHALL cover 0x80000000 / 0xFFFFFFFF -> quotient 0x80000000, remainder 0, div_by_zero 0.
REQ-031 SHALL cover 5 / 0 -> quotient 0xFFFFFFFF, remainder 5, div_by_zero 1, same latency.
REQ-032 SHALL cover clr low at iteration 10 -> all outputs 0 immediately, no done; then 9 / 3 -> 3, 0.
REQ-033 SHALL cover start pulsed while busy (ignored, result unchanged) and start in done cycle (second result 33 edges later).

Source files
------------

// File: rtl/divide_pkg.sv
// Shared definitions for the sequential signed divider: default width,
// controller state encoding and iteration-counter sizing.
package divide_pkg;

    localparam int DEFAULT_BITS = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_t;

    // The counter has to represent BITS itself, hence the extra bit.
    function automatic int cnt_width(input int bits);
        return $clog2(bits) + 1;
    endfunction

endpackage

// File: rtl/divide_negate.sv
// Conditional two's-complement negation, used both to take operand
// magnitudes and to restore the signs of the results.
module divide_negate #(
    parameter int W = 32
) (
    input  logic [W-1:0] value,
    input  logic         en,
    output logic [W-1:0] result
);

    assign result = en ? (~value + W'(1)) : value;

endmodule

// File: rtl/divide.sv
// Multi-cycle signed divider: one restoring quotient bit per clock on the
// operand magnitudes, then a single fix-up cycle that restores the signs.
module divide
    import divide_pkg::*;
#(
    parameter int BITS = DEFAULT_BITS
) (
    input  logic            clk,
    input  logic            clr,
    input  logic            start,
    input  logic [BITS-1:0] dividend,
    input  logic [BITS-1:0] divisor,
    output logic            busy,
    output logic            done,
    output logic [BITS-1:0] quotient,
    output logic [BITS-1:0] remainder,
    output logic            div_by_zero
);

    localparam int            CW   = cnt_width(BITS);
    localparam logic [CW-1:0] LAST = CW'(BITS - 1);

    state_t          state, state_next;
    logic [CW-1:0]   cnt;
    logic [BITS:0]   prem;
    logic [BITS-1:0] qreg, dvs_mag, dvd_raw;
    logic            neg_q, neg_r, zero_dvs;

    logic [BITS-1:0] dvd_abs, dvs_abs, q_fixed, r_fixed;
    logic [BITS+1:0] shifted, diff;

    divide_negate #(.W(BITS)) u_dvd_abs (.value(dividend),         .en(dividend[BITS-1]), .result(dvd_abs));
    divide_negate #(.W(BITS)) u_dvs_abs (.value(divisor),          .en(divisor[BITS-1]),  .result(dvs_abs));
    divide_negate #(.W(BITS)) u_q_fix   (.value(qreg),             .en(neg_q),            .result(q_fixed));
    divide_negate #(.W(BITS)) u_r_fix   (.value(prem[BITS-1:0]),   .en(neg_r),            .result(r_fixed));

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) state <= IDLE;
        else      state <= state_next;
    end

    // NOTE: defaults come first so no path leaves state_next unassigned,
    // which would otherwise infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (cnt == LAST) state_next = FIX;
            FIX:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Trial subtraction; a borrow out of the top bit means "restore".
    always_comb begin
        shifted = {1'b0, prem, qreg[BITS-1]};
        diff    = shifted - {2'b00, dvs_mag};
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            cnt         <= '0;
            prem        <= '0;
            qreg        <= '0;
            dvs_mag     <= '0;
            dvd_raw     <= '0;
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
            zero_dvs    <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        dvd_raw  <= dividend;
                        dvs_mag  <= dvs_abs;
                        qreg     <= dvd_abs;
                        prem     <= '0;
                        cnt      <= '0;
                        neg_q    <= dividend[BITS-1] ^ divisor[BITS-1];
                        neg_r    <= dividend[BITS-1];
                        zero_dvs <= (divisor == '0);
                        busy     <= 1'b1;
                    end
                end
                RUN: begin
                    cnt <= cnt + CW'(1);
                    if (!diff[BITS+1]) begin
                        prem <= diff[BITS:0];
                        qreg <= {qreg[BITS-2:0], 1'b1};
                    end else begin
                        prem <= shifted[BITS:0];
                        qreg <= {qreg[BITS-2:0], 1'b0};
                    end
                end
                FIX: begin
                    busy        <= 1'b0;
                    done        <= 1'b1;
                    div_by_zero <= zero_dvs;
                    if (zero_dvs) begin
                        quotient  <= '1;
                        remainder <= dvd_raw;
                    end else begin
                        quotient  <= q_fixed;
                        remainder <= r_fixed;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_divide.sv
// Randomized self-checking bench for divide against an arithmetic model
// built on the simulator's own signed division.
module tb_divide;

    localparam int BITS    = 32;
    localparam int LATENCY = BITS + 1;

    logic            clk = 1'b0;
    logic            clr, start;
    logic [BITS-1:0] dividend, divisor;
    logic            busy, done, div_by_zero;
    logic [BITS-1:0] quotient, remainder;

    int vectors     = 0;
    int miscompares = 0;

    divide #(.BITS(BITS)) dut (
        .clk(clk), .clr(clr), .start(start),
        .dividend(dividend), .divisor(divisor),
        .busy(busy), .done(done),
        .quotient(quotient), .remainder(remainder),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Truncating signed division with the two architected special cases.
    task automatic model(input logic [BITS-1:0] a, input logic [BITS-1:0] b,
                         output logic [BITS-1:0] q, output logic [BITS-1:0] r,
                         output logic z);
        int sa, sb;
        sa = $signed(a);
        sb = $signed(b);
        z  = 1'b0;
        if (sb == 0) begin
            q = '1;
            r = a;
            z = 1'b1;
        end else if (sa == 32'sh8000_0000 && sb == -1) begin
            q = 32'h8000_0000;
            r = '0;
        end else begin
            q = BITS'(sa / sb);
            r = BITS'(sa % sb);
        end
    endtask

    // Called #1 after an edge; returns #1 after the edge that sampled start.
    task automatic start_op(input logic [BITS-1:0] a, input logic [BITS-1:0] b);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
        dividend = $urandom;
        divisor  = $urandom;
        check("busy_after_start", busy, 1);
    endtask

    // Counts edges to done; optionally pulses start mid-run at edge poke_at.
    task automatic wait_done(input string tag, input int poke_at);
        int n;
        bit held;
        n    = 0;
        held = 1'b1;
        do begin
            @(posedge clk);
            #1;
            n++;
            if (start) start = 1'b0;
            if (n == poke_at) begin
                start    = 1'b1;
                dividend = 32'd7;
                divisor  = 32'd1;
            end
            if (!done && !busy) held = 1'b0;
        end while (!done && n < 2 * LATENCY);
        check({tag, "_latency"}, n, LATENCY);
        check({tag, "_busy_held"}, held, 1);
        check({tag, "_busy_in_done"}, busy, 0);
    endtask

    task automatic run_check(input string tag, input logic [BITS-1:0] a,
                             input logic [BITS-1:0] b, input int poke_at);
        logic [BITS-1:0] eq, er;
        logic ez;
        model(a, b, eq, er, ez);
        start_op(a, b);
        wait_done(tag, poke_at);
        check({tag, "_q"}, quotient, eq);
        check({tag, "_r"}, remainder, er);
        check({tag, "_dz"}, div_by_zero, ez);
    endtask

    initial begin
        logic [BITS-1:0] a, b, eq, er;
        logic ez;
        int dc;

        clr      = 1'b0;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        #12;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_q", quotient, 0);
        check("rst_r", remainder, 0);
        check("rst_dz", div_by_zero, 0);
        clr = 1'b1;
        @(posedge clk);
        #1;

        run_check("p100_d7",   32'd100,          32'd7,          -1);
        run_check("n100_d7",   -32'sd100,        32'd7,          -1);
        run_check("p100_nd7",  32'd100,          -32'sd7,        -1);
        run_check("min_neg1",  32'h8000_0000,    32'hFFFF_FFFF,  -1);
        run_check("p5_d0",     32'd5,            32'd0,          -1);
        run_check("min_d1",    32'h8000_0000,    32'd1,          -1);
        run_check("n7_d0",     -32'sd7,          32'd0,          -1);

        // Abort mid-run: outputs drop at once and no done ever appears.
        start_op(32'd200, 32'd9);
        repeat (10) @(posedge clk);
        #1;
        clr = 1'b0;
        #1;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_q", quotient, 0);
        check("abort_r", remainder, 0);
        check("abort_dz", div_by_zero, 0);
        @(posedge clk);
        #2;
        clr = 1'b1;
        dc  = 0;
        repeat (2 * LATENCY) begin
            @(posedge clk);
            #1;
            if (done) dc++;
        end
        check("abort_no_done", dc, 0);
        run_check("p9_d3", 32'd9, 32'd3, -1);

        // Start pulsed while busy is ignored.
        run_check("poke", 32'd12345, -32'sd17, 8);

        // Back-to-back start in the done cycle; old result holds until FIX.
        run_check("b2b1", -32'sd1000, 32'd3, -1);
        model(-32'sd1000, 32'd3, eq, er, ez);
        a = 32'd77;
        b = 32'd5;
        start_op(a, b);
        check("b2b_hold_q", quotient, eq);
        check("b2b_hold_r", remainder, er);
        model(a, b, eq, er, ez);
        wait_done("b2b2", -1);
        check("b2b2_q", quotient, eq);
        check("b2b2_r", remainder, er);
        check("b2b2_dz", div_by_zero, ez);

        for (int i = 0; i < 16; i++) begin
            a = (i % 5 == 0) ? 32'h8000_0000 : 32'($urandom);
            case ($urandom_range(0, 3))
                0:       b = '0;
                1:       b = 32'($signed($urandom_range(0, 15)) - 8);
                2:       b = 32'($urandom_range(1, 1000));
                default: b = 32'($urandom);
            endcase
            run_check($sformatf("rnd%0d", i), a, b, -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
